mark_capture: RTL and testbench
===============================

# mark_capture

Measures a single marker pulse on a digital input, relative to an arm strobe, and encodes it as a 64-bit command word using the same start/length field layout the marker generator decodes. It sits on the return path of the marker channel, so loop-back tests and timing calibration can read a generated mark back as a command. The arm strobe is the same `cstrobe` that fires the generator, so a looped-back mark reproduces its original start/length fields exactly.

## Interface
- `TIMEOUT`, default 4095: maximum cycles to wait for a rising edge after the counter starts; 1..4095.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cstrobe`  in  1  arm strobe, one-cycle pulse; starts or restarts a measurement.
- `mark`  in  1  marker input, synchronous to `clk`.
- `command`  out  64  result word; held until the next result.
- `cstrobe_out`  out  1  one-cycle pulse when `command` is updated.
- `busy`  out  1  high while a measurement is in progress.

## Operation
- Result layout:
  - [63:62] = 0; [61:50] = start; [49:38] = length; [37:2] = 0.
  - [1] = saturated (length clipped); [0] = timeout.
- States:
  - IDLE → SYNC on `cstrobe`.
  - SYNC: one cycle; then ARMED with `cnt` = 0.
  - ARMED: `cnt` +1 per cycle. Rise seen → HIGH. `cnt` reaches `TIMEOUT` with no rise → EMIT, timeout result.
  - HIGH: `len` +1 per cycle while `mark` = 1. `mark` = 0 → EMIT. `len` reaches 4095 → EMIT, saturated result.
  - EMIT: one cycle; loads `command`, pulses `cstrobe_out`, returns to IDLE.
- Rise detection: `mark` = 1 with the previous-cycle sample `mark_d` = 0. `mark_d` is registered every cycle, including in IDLE.
- A rise while `cnt` = 0 (mark already rising at arm) is ignored; capture waits for the next rise.
- Start = `cnt` − 1, sampled in the first cycle `mark` is high.
- Length = number of consecutive cycles `mark` is high, 12-bit unsigned.
- Timeout result: start = 0xFFF, length = 0, bit0 = 1.
- Saturated result: length = 0xFFF, bit1 = 1; start is valid.
- `cstrobe` in any non-IDLE state aborts the measurement without emitting, and re-enters SYNC.
- `cstrobe` during EMIT: the emit completes in that cycle, then the block re-enters SYNC.
- `busy` = 1 in SYNC, ARMED and HIGH.
- Reset values: `command` = 0, `cstrobe_out` = 0, `busy` = 0, state IDLE, counters 0, `mark_d` = 0.
- Reset mid-measurement discards it; no `cstrobe_out`.

## Timing
- `cstrobe` is high in cycle 0. SYNC occupies cycle 1; `cnt` = 0 in cycle 2.
- A mark first high in cycle c gives start = c − 3.
- A mark last high in cycle d gives length = d − c + 1.
- Falling edge sampled in cycle d+1; `cstrobe_out` and the new `command` are visible in cycle d+2.
- Timeout: `cstrobe_out` in cycle `TIMEOUT` + 3.
- Arm-to-re-arm: back-to-back operation needs no dead cycles after EMIT.

## Structure
- Shared package (same package as the marker generator):
  - field positions START_MSB = 61, START_LSB = 50, LEN_MSB = 49, LEN_LSB = 38, field width 12, flag bit indices;
  - state enum {IDLE, SYNC, ARMED, HIGH, EMIT}.
- One sub-module is natural: `mark_edge_det` (registered `mark_d`, rise/fall outputs).
- Everything else lives in one FSM plus two 12-bit counters.

## Test plan
- Arm at cycle 0; mark high cycles 13..17 → `cstrobe_out` at cycle 19; `command`[61:50] = 10, [49:38] = 5, flags 0.
- Loop-back: a generator command with start = 100, length = 7 drives `mark`; the same `cstrobe` arms this block → returned fields are 100 and 7.
- `TIMEOUT` = 20, no mark → `cstrobe_out` at cycle 23; start = 0xFFF, length = 0, bit0 = 1.
- Mark held high for 5000 cycles from cycle 3 → start = 0, length = 0xFFF, bit1 = 1; one pulse only.
- Re-arm at cycle 8 during HIGH (rise at cycle 6), then mark pulse at cycles 20..21 → single result: start = 9, length = 2.
- `rst_n` low during HIGH → no `cstrobe_out`; `command` = 0; `busy` = 0 immediately (asynchronous).

Source files
------------

// File: rtl/mark_capture_pkg.sv
// mark_capture_pkg
//   Shared definitions for the marker channel: command word field positions,
//   flag bit indices, the capture FSM state encoding and a command packer.
package mark_capture_pkg;

  localparam int FIELD_W   = 12;
  localparam int START_MSB = 61;
  localparam int START_LSB = 50;
  localparam int LEN_MSB   = 49;
  localparam int LEN_LSB   = 38;
  localparam int SAT_BIT   = 1;   // length was clipped at FIELD_MAX
  localparam int TMO_BIT   = 0;   // no rising edge before the timeout

  localparam logic [FIELD_W-1:0] FIELD_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_ARMED = 3'd2,
    ST_HIGH  = 3'd3,
    ST_EMIT  = 3'd4
  } state_e;

  // Assemble a command word; every bit outside the fields and flags is zero.
  function automatic logic [63:0] pack_command(
    input logic [FIELD_W-1:0] start,
    input logic [FIELD_W-1:0] len,
    input logic               sat,
    input logic               tmo
  );
    logic [63:0] cmd;
    cmd                     = '0;
    cmd[START_MSB:START_LSB] = start;
    cmd[LEN_MSB:LEN_LSB]     = len;
    cmd[SAT_BIT]             = sat;
    cmd[TMO_BIT]             = tmo;
    return cmd;
  endfunction

endpackage

// File: rtl/mark_capture_edge_det.sv
// mark_edge_det
//   Registers the marker input every cycle and flags its edges.
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset
//   i_mark   : marker input (synchronous to i_clk)
//   o_rise   : i_mark high this cycle, low last cycle
//   o_fall   : i_mark low this cycle, high last cycle
module mark_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_mark,
  output logic o_rise,
  output logic o_fall
);

  logic r_mark_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mark_d <= 1'b0;
    end else begin
      r_mark_d <= i_mark;
    end
  end

  assign o_rise = i_mark & ~r_mark_d;
  assign o_fall = ~i_mark & r_mark_d;

endmodule

// File: rtl/mark_capture.sv
// mark_capture
//   Measures one marker pulse relative to the arm strobe and returns it as a
//   command word (start/length fields plus saturated/timeout flags).
//   TIMEOUT     : cycles to wait for a rising edge once counting starts (1..4095)
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   cstrobe     : arm strobe; starts or restarts a measurement
//   mark        : marker input
//   command     : result word, held until the next result
//   cstrobe_out : one-cycle pulse, coincident with a new command
//   busy        : measurement in progress (SYNC, ARMED, HIGH)
module mark_capture
  import mark_capture_pkg::*;
#(
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cstrobe,
  input  logic        mark,
  output logic [63:0] command,
  output logic        cstrobe_out,
  output logic        busy
);

  localparam logic [FIELD_W-1:0] TIMEOUT_C = FIELD_W'(TIMEOUT);

  state_e             r_state;
  logic [FIELD_W-1:0] r_cnt;
  logic [FIELD_W-1:0] r_len;
  logic [FIELD_W-1:0] r_start;
  logic [63:0]        r_command;
  logic               r_cstrobe_out;

  state_e             w_state_next;
  logic [FIELD_W-1:0] w_cnt_next;
  logic [FIELD_W-1:0] w_len_next;
  logic [FIELD_W-1:0] w_start_next;
  logic [63:0]        w_command_next;
  logic               w_cstrobe_out_next;
  logic               w_rise;
  logic               w_fall;

  mark_edge_det u_edge (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_mark  (mark),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // The result is registered on the transition into EMIT, so command and
  // cstrobe_out are already valid during the EMIT cycle itself.
  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_len_next         = r_len;
    w_start_next       = r_start;
    w_command_next     = r_command;
    w_cstrobe_out_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_IDLE;
      end
      ST_SYNC: begin
        w_cnt_next   = '0;
        w_len_next   = '0;
        w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        // A rise at cnt = 0 was already in progress at arm time; skip it.
        if (w_rise && (r_cnt != '0)) begin
          w_start_next = r_cnt - FIELD_W'(1);
          w_len_next   = FIELD_W'(1);
          w_state_next = ST_HIGH;
        end else if (r_cnt == TIMEOUT_C) begin
          w_command_next     = pack_command(FIELD_MAX, '0, 1'b0, 1'b1);
          w_cstrobe_out_next = 1'b1;
          w_state_next       = ST_EMIT;
        end else begin
          w_cnt_next = r_cnt + FIELD_W'(1);
        end
      end
      ST_HIGH: begin
        if (w_fall) begin
          w_command_next     = pack_command(r_start, r_len, 1'b0, 1'b0);
          w_cstrobe_out_next = 1'b1;
          w_state_next       = ST_EMIT;
        end else if (r_len == FIELD_MAX) begin
          w_command_next     = pack_command(r_start, FIELD_MAX, 1'b1, 1'b0);
          w_cstrobe_out_next = 1'b1;
          w_state_next       = ST_EMIT;
        end else begin
          w_len_next = r_len + FIELD_W'(1);
        end
      end
      ST_EMIT: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Arm strobe wins everywhere: an in-flight measurement is dropped
    // without a result. In EMIT the result is already out, so nothing is lost.
    if (cstrobe) begin
      w_state_next       = ST_SYNC;
      w_command_next     = r_command;
      w_cstrobe_out_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_len         <= '0;
      r_start       <= '0;
      r_command     <= '0;
      r_cstrobe_out <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_len         <= w_len_next;
      r_start       <= w_start_next;
      r_command     <= w_command_next;
      r_cstrobe_out <= w_cstrobe_out_next;
    end
  end

  // Decoded from the state register so reset clears it immediately.
  assign busy        = (r_state == ST_SYNC) || (r_state == ST_ARMED) || (r_state == ST_HIGH);
  assign command     = r_command;
  assign cstrobe_out = r_cstrobe_out;

endmodule

// File: tb/tb_mark_capture.sv
module tb_mark_capture;

  logic        clk;
  logic        rst_n;
  logic        cstrobe;
  logic        mark;
  logic [63:0] cmd_def, cmd_to;
  logic        cso_def, cso_to;
  logic        busy_def, busy_to;

  int n_tests = 0;
  int n_fail  = 0;

  mark_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cstrobe     (cstrobe),
    .mark        (mark),
    .command     (cmd_def),
    .cstrobe_out (cso_def),
    .busy        (busy_def)
  );

  mark_capture #(.TIMEOUT(20)) dut_to (
    .clk         (clk),
    .rst_n       (rst_n),
    .cstrobe     (cstrobe),
    .mark        (mark),
    .command     (cmd_to),
    .cstrobe_out (cso_to),
    .busy        (busy_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          c1, d1, c2, d2;  // mark high intervals (-1 = unused)
    int          rearm;           // extra cstrobe cycle (-1 = none)
    bit          use_to;          // observe the TIMEOUT=20 instance
    int          exp_cyc;         // expected cstrobe_out cycle
    logic [11:0] st, ln;
    logic        sat, tmo;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [63:0] mk_cmd(input logic [11:0] st, input logic [11:0] ln,
                                         input logic sat, input logic tmo);
    return {2'b00, st, ln, 36'd0, sat, tmo};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          limit, first, pulses;
    logic [63:0] cap;
    logic        b1, bpre, bat, cs, bs;
    limit  = v.exp_cyc;
    if (v.d1 > limit) limit = v.d1;
    if (v.d2 > limit) limit = v.d2;
    limit  = limit + 8;
    first  = -1;
    pulses = 0;
    cap    = '0;
    b1 = 1'b0; bpre = 1'b0; bat = 1'b1;
    for (int k = 0; k <= limit; k++) begin
      cstrobe = (k == 0) || (k == v.rearm);
      mark    = ((k >= v.c1) && (k <= v.d1) && (v.c1 >= 0)) ||
                ((k >= v.c2) && (k <= v.d2) && (v.c2 >= 0));
      cs = v.use_to ? cso_to  : cso_def;
      bs = v.use_to ? busy_to : busy_def;
      if (cs) begin
        pulses++;
        if (first < 0) begin
          first = k;
          cap   = v.use_to ? cmd_to : cmd_def;
        end
      end
      if (k == 1)             b1   = bs;
      if (k == v.exp_cyc - 1) bpre = bs;
      if (k == v.exp_cyc)     bat  = bs;
      step();
    end
    cstrobe = 1'b0;
    mark    = 1'b0;
    repeat (3) step();
    $display("[TB] vec %0d: pulse at cycle %0d, %0d pulse(s), command 0x%016h", idx, first, pulses, cap);
    check($sformatf("vec%0d pulse_cycle", idx), 64'(first), 64'(v.exp_cyc));
    check($sformatf("vec%0d pulse_count", idx), 64'(pulses), 64'd1);
    check($sformatf("vec%0d command", idx), cap, mk_cmd(v.st, v.ln, v.sat, v.tmo));
    check($sformatf("vec%0d busy_sync", idx), 64'(b1), 64'd1);
    check($sformatf("vec%0d busy_before_emit", idx), 64'(bpre), 64'd1);
    check($sformatf("vec%0d busy_in_emit", idx), 64'(bat), 64'd0);
  endtask

  initial begin
    int          pulses;
    logic [63:0] caps[2];
    int          cyc[2];
    logic        b9;

    //            c1   d1    c2  d2  rearm to  cyc   start    len      sat   tmo
    vecs[0] = '{ 13,  17,   -1, -1, -1, 1'b0,   19, 12'd10,  12'd5,   1'b0, 1'b0};
    vecs[1] = '{103, 109,   -1, -1, -1, 1'b0,  111, 12'd100, 12'd7,   1'b0, 1'b0};
    vecs[2] = '{  2,   5,   10, 11, -1, 1'b0,   13, 12'd7,   12'd2,   1'b0, 1'b0};
    vecs[3] = '{  4,   4,   -1, -1, -1, 1'b0,    6, 12'd1,   12'd1,   1'b0, 1'b0};
    vecs[4] = '{  3,   3,   -1, -1, -1, 1'b0,    5, 12'd0,   12'd1,   1'b0, 1'b0};
    vecs[5] = '{ -1,  -1,   -1, -1, -1, 1'b1,   23, 12'hFFF, 12'd0,   1'b0, 1'b1};
    vecs[6] = '{  6,  12,   20, 21,  8, 1'b0,   23, 12'd9,   12'd2,   1'b0, 1'b0};
    vecs[7] = '{ 22,  23,   -1, -1, -1, 1'b1,   25, 12'd19,  12'd2,   1'b0, 1'b0};
    vecs[8] = '{ 23,  24,   -1, -1, -1, 1'b1,   23, 12'hFFF, 12'd0,   1'b0, 1'b1};
    vecs[9] = '{  3, 5002,  -1, -1, -1, 1'b0, 4099, 12'd0,   12'hFFF, 1'b1, 1'b0};

    rst_n   = 1'b0;
    cstrobe = 1'b0;
    mark    = 1'b0;
    repeat (3) step();
    check("reset command", cmd_def, 64'd0);
    check("reset cstrobe_out", 64'(cso_def), 64'd0);
    check("reset busy", 64'(busy_def), 64'd0);
    check("reset busy_to", 64'(busy_to), 64'd0);
    rst_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Re-arm during EMIT: first result completes, second follows with no gap.
    pulses = 0;
    cyc[0] = -1; cyc[1] = -1;
    caps[0] = '0; caps[1] = '0;
    b9 = 1'b0;
    for (int k = 0; k <= 26; k++) begin
      cstrobe = (k == 0) || (k == 8);
      mark    = ((k >= 5) && (k <= 6)) || ((k >= 15) && (k <= 16));
      if (k == 9) b9 = busy_def;
      if (cso_def) begin
        if (pulses < 2) begin
          cyc[pulses]  = k;
          caps[pulses] = cmd_def;
        end
        pulses++;
      end
      step();
    end
    cstrobe = 1'b0;
    mark    = 1'b0;
    repeat (3) step();
    $display("[TB] b2b: %0d pulse(s) at %0d/%0d, commands 0x%016h 0x%016h", pulses, cyc[0], cyc[1], caps[0], caps[1]);
    check("b2b pulse_count", 64'(pulses), 64'd2);
    check("b2b first_cycle", 64'(cyc[0]), 64'd8);
    check("b2b first_command", caps[0], mk_cmd(12'd2, 12'd2, 1'b0, 1'b0));
    check("b2b second_cycle", 64'(cyc[1]), 64'd18);
    check("b2b second_command", caps[1], mk_cmd(12'd4, 12'd2, 1'b0, 1'b0));
    check("b2b busy_after_rearm", 64'(b9), 64'd1);

    // Reset in HIGH: measurement discarded, outputs cleared at once.
    pulses = 0;
    b9 = 1'b0;
    for (int k = 0; k <= 45; k++) begin
      cstrobe = (k == 0);
      mark    = (k >= 6) && (k <= 30);
      if (k == 9) b9 = busy_def;
      if (cso_def) pulses++;
      if (k == 10) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid busy", 64'(busy_def), 64'd0);
        check("rst_mid command", cmd_def, 64'd0);
        check("rst_mid cstrobe_out", 64'(cso_def), 64'd0);
      end
      if (k == 12) rst_n = 1'b1;
      step();
    end
    mark = 1'b0;
    $display("[TB] reset mid-HIGH: busy before reset %0b, %0d pulse(s) afterwards", b9, pulses);
    check("rst_mid busy_before", 64'(b9), 64'd1);
    check("rst_mid pulse_count", 64'(pulses), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
